// File: rtl/cfg_chain_loader.sv
// Serial config-chain frame generator: START, ID (LSB first), PAYLOAD (bit 0 first), GAP.
// Optional build macro CFG_LOADER_PARITY_EN inserts an even-parity cycle after PAYLOAD.

module cfg_chain_loader #(
   parameter int WORD_W     = 16,
   parameter int ID_WIDTH   = 3,
   parameter int LEN_W      = 12,
   parameter int GAP_CYCLES = 2
) (
   input  logic                clk,
   input  logic                crst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ID_WIDTH-1:0] cmd_id,
   input  logic [LEN_W-1:0]    cmd_len,
   input  logic                data_valid,
   output logic                data_ready,
   input  logic [WORD_W-1:0]   data,
   output logic                cfg_out_start,
   output logic                cfg_bit_out,
   output logic                busy,
   output logic                frame_done,
   output logic                err_underrun
);

   localparam int IDC_W = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int SC_W  = $clog2(WORD_W + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ID,
      S_PAYLOAD,
`ifdef CFG_LOADER_PARITY_EN
      S_PARITY,
`endif
      S_GAP
   } state_t;

   state_t              state_q;
   logic [ID_WIDTH-1:0] id_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W:0]      need_q, need_d, acc_cnt_q;
   logic [IDC_W-1:0]    id_cnt_q;
   logic [GAP_W-1:0]    gap_cnt_q;
   logic [WORD_W-1:0]   sh_q, hold_q;
   logic [SC_W-1:0]     sh_cnt_q;
   logic                hold_v_q, abort_q;
   logic                start_q, bit_q, done_q, err_q;
`ifdef CFG_LOADER_PARITY_EN
   logic                par_q;
`endif

   logic adv_w, shift_w, have_w, next_bit_w, accept_w;

   assign cmd_ready     = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign cfg_out_start = start_q;
   assign cfg_bit_out   = bit_q;
   assign frame_done    = done_q;
   assign err_underrun  = err_q;

   assign data_ready = ((state_q == S_START) || (state_q == S_ID) || (state_q == S_PAYLOAD))
                       && !hold_v_q && (acc_cnt_q < need_q);
   assign accept_w   = data_valid && data_ready;

   // adv_w marks the edge leaving the last ID cycle or any PAYLOAD cycle; shift_w means a bit is due.
   always_comb begin
      need_d     = (LEN_W+1)'((32'(cmd_len) + WORD_W - 1) / WORD_W);
      adv_w      = ((state_q == S_ID) && (id_cnt_q == IDC_W'(ID_WIDTH - 1))) || (state_q == S_PAYLOAD);
      shift_w    = adv_w && (len_q != '0);
      have_w     = (sh_cnt_q != '0) || hold_v_q || accept_w;
      next_bit_w = (sh_cnt_q != '0) ? sh_q[0] : (hold_v_q ? hold_q[0] : data[0]);
   end

   always_ff @(posedge clk or posedge crst) begin
      if (crst) begin
         state_q   <= S_IDLE;
         id_q      <= '0;
         len_q     <= '0;
         need_q    <= '0;
         acc_cnt_q <= '0;
         id_cnt_q  <= '0;
         gap_cnt_q <= '0;
         sh_q      <= '0;
         sh_cnt_q  <= '0;
         hold_q    <= '0;
         hold_v_q  <= 1'b0;
         abort_q   <= 1'b0;
         start_q   <= 1'b0;
         bit_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef CFG_LOADER_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         start_q <= 1'b0;
         bit_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         if (accept_w) acc_cnt_q <= acc_cnt_q + 1'b1;

         // A word accepted on the edge the shifter runs dry feeds the shifter directly.
         if (shift_w && have_w) begin
            if (sh_cnt_q != '0) begin
               sh_q     <= sh_q >> 1;
               sh_cnt_q <= sh_cnt_q - 1'b1;
               if (accept_w) begin
                  hold_q   <= data;
                  hold_v_q <= 1'b1;
               end
            end else if (hold_v_q) begin
               sh_q     <= hold_q >> 1;
               sh_cnt_q <= SC_W'(WORD_W - 1);
               hold_v_q <= 1'b0;
            end else begin
               sh_q     <= data >> 1;
               sh_cnt_q <= SC_W'(WORD_W - 1);
            end
         end else if (accept_w) begin
            if (sh_cnt_q == '0) begin
               sh_q     <= data;
               sh_cnt_q <= SC_W'(WORD_W);
            end else begin
               hold_q   <= data;
               hold_v_q <= 1'b1;
            end
         end

`ifdef CFG_LOADER_PARITY_EN
         if (state_q == S_IDLE) par_q <= 1'b0;
         else if ((state_q == S_ID) || (state_q == S_PAYLOAD)) par_q <= par_q ^ bit_q;
`endif

         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  state_q   <= S_START;
                  start_q   <= 1'b1;
                  id_q      <= cmd_id;
                  len_q     <= cmd_len;
                  need_q    <= need_d;
                  acc_cnt_q <= '0;
                  abort_q   <= 1'b0;
                  sh_cnt_q  <= '0;
                  hold_v_q  <= 1'b0;
               end
            end
            S_START: begin
               state_q  <= S_ID;
               bit_q    <= id_q[0];
               id_q     <= id_q >> 1;
               id_cnt_q <= '0;
            end
            S_ID: begin
               if (id_cnt_q != IDC_W'(ID_WIDTH - 1)) begin
                  bit_q    <= id_q[0];
                  id_q     <= id_q >> 1;
                  id_cnt_q <= id_cnt_q + 1'b1;
               end
            end
`ifdef CFG_LOADER_PARITY_EN
            S_PARITY: begin
               state_q   <= S_GAP;
               gap_cnt_q <= '0;
               done_q    <= (GAP_CYCLES == 1);
            end
`endif
            S_GAP: begin
               if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                  state_q  <= S_IDLE;
                  sh_cnt_q <= '0;
                  hold_v_q <= 1'b0;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
                  done_q    <= !abort_q && ((32'(gap_cnt_q) + 2) == GAP_CYCLES);
               end
            end
            default: ;
         endcase

         // The underrun cycle itself is the first GAP cycle.
         if (adv_w) begin
            if (shift_w) begin
               if (!have_w) begin
                  state_q   <= S_GAP;
                  gap_cnt_q <= '0;
                  err_q     <= 1'b1;
                  abort_q   <= 1'b1;
               end else begin
                  state_q <= S_PAYLOAD;
                  bit_q   <= next_bit_w;
                  len_q   <= len_q - 1'b1;
               end
            end else begin
`ifdef CFG_LOADER_PARITY_EN
               state_q <= S_PARITY;
               bit_q   <= par_q ^ bit_q;
`else
               state_q   <= S_GAP;
               gap_cnt_q <= '0;
               done_q    <= (GAP_CYCLES == 1);
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Randomized bench for cfg_chain_loader: per-cycle frame model built from the frame layout rules.
// Honours CFG_LOADER_PARITY_EN for the parity cycle.

module tb_cfg_chain_loader;

   localparam int W    = 16;
   localparam int IW   = 3;
   localparam int LW   = 12;
   localparam int GAPC = 2;
`ifdef CFG_LOADER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic          clk = 1'b0;
   logic          crst;
   logic          cmd_valid, cmd_ready;
   logic [IW-1:0] cmd_id;
   logic [LW-1:0] cmd_len;
   logic          data_valid, data_ready;
   logic [W-1:0]  data;
   logic          cfg_out_start, cfg_bit_out, busy, frame_done, err_underrun;
   logic [5:0]    obs;

   int n_tests = 0;
   int n_fail  = 0;

   cfg_chain_loader #(.WORD_W(W), .ID_WIDTH(IW), .LEN_W(LW), .GAP_CYCLES(GAPC)) dut (
      .clk(clk), .crst(crst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_len(cmd_len),
      .data_valid(data_valid), .data_ready(data_ready), .data(data),
      .cfg_out_start(cfg_out_start), .cfg_bit_out(cfg_bit_out), .busy(busy),
      .frame_done(frame_done), .err_underrun(err_underrun)
   );

   always #5 clk = ~clk;

   // {start, bit, done, err, busy, cmd_ready}
   assign obs = {cfg_out_start, cfg_bit_out, frame_done, err_underrun, busy, cmd_ready};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Mode 0: data_valid always 1; mode 1: random 70%; mode 2: word hold_idx never offered.
   task automatic run_frame(input logic [IW-1:0] id, input int len, input int mode,
                            input int hold_idx, input logic use_w0, input logic [W-1:0] w0);
      logic [W-1:0] words[$];
      logic [W-1:0] tw;
      int  nw, n_acc, abort_c, ps, pe, gl, k;
      logic par, es, eb, ed, ee, dv, aborted, fin;
      nw = (len + W - 1) / W;
      for (int i = 0; i < nw; i++) words.push_back((i == 0 && use_w0) ? w0 : W'($urandom));
      ps = 2 + IW;
      pe = ps + len - 1;
      gl = pe + PAR + GAPC;
      @(negedge clk);
      check("idle_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_id = id; cmd_len = LW'(len); data_valid = 1'b0;
      n_acc = 0; abort_c = 0; aborted = 1'b0; fin = 1'b0; par = 1'b0;
      for (int c = 1; c <= gl + 5 && !fin; c++) begin
         @(negedge clk);
         cmd_valid = 1'b0; cmd_id = IW'($urandom); cmd_len = LW'($urandom);
         es = 1'b0; eb = 1'b0; ed = 1'b0; ee = 1'b0;
         if (aborted) begin
            if (c == abort_c + GAPC) begin
               check("abort_idle", obs, 6'b000001);
               fin = 1'b1;
            end else check("abort_gap", obs, 6'b000010);
         end else if (c > gl) begin
            check("end_idle", obs, 6'b000001);
            fin = 1'b1;
         end else begin
            if (c == 1) es = 1'b1;
            else if (c <= 1 + IW) begin
               eb = id[c-2]; par ^= eb;
            end else if (c <= pe) begin
               k = c - ps;
               if ((k % W) == 0 && (k / W) >= n_acc) begin
                  ee = 1'b1; aborted = 1'b1; abort_c = c;
                  if (mode == 0) check("prefetch", n_acc, k / W + 1);
               end else begin
                  tw = words[k / W]; eb = tw[k % W]; par ^= eb;
               end
            end else if (PAR == 1 && c == pe + 1) eb = par;
            else ed = (c == gl);
            if (ee) check("underrun", obs, {es, eb, ed, ee, 2'b10});
            else    check("frame_out", obs, {es, eb, ed, ee, 2'b10});
         end
         if (!fin) begin
            if (aborted || c > pe || n_acc >= nw) check("drdy_off", data_ready, 0);
            case (mode)
               0:       dv = 1'b1;
               1:       dv = ($urandom_range(0, 99) < 70);
               default: dv = (n_acc != hold_idx);
            endcase
            data_valid = dv;
            data = (n_acc < nw) ? words[n_acc] : W'($urandom);
            if (dv && data_ready) n_acc++;
         end
      end
      data_valid = 1'b0;
      if (!fin) check("frame_timeout", cmd_ready, 1);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_id = 3'd4; cmd_len = 12'd64;
      data_valid = 1'b1; data = W'($urandom);
      repeat (12) begin
         @(negedge clk);
         cmd_valid = 1'b0;
      end
      check("pre_reset_busy", busy, 1);
      #1 crst = 1'b1;
      #1;
      check("reset_async", obs, 6'b000001);
      check("reset_drdy", data_ready, 0);
      @(negedge clk);
      crst = 1'b0; data_valid = 1'b0;
      @(negedge clk);
      check("post_reset", obs, 6'b000001);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      crst = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_len = '0; data_valid = 1'b0; data = '0;
      repeat (3) @(negedge clk);
      check("reset_state", obs, 6'b000001);
      check("reset_drdy0", data_ready, 0);
      crst = 1'b0;

      run_frame(3'd5, 16, 0, -1, 1'b1, 16'hA5C3);
      run_frame(3'd3, 192, 0, -1, 1'b0, '0);
      run_frame(3'd6, 20, 2, 1, 1'b0, '0);
      run_frame(3'd2, 0, 0, -1, 1'b0, '0);
`ifdef CFG_LOADER_PARITY_EN
      run_frame(3'd1, 4, 0, -1, 1'b1, 16'h0007);
`endif
      mid_reset();

      for (int t = 0; t < 40; t++) begin
         int len;
         len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 300)) : int'($urandom_range(0, 60));
         run_frame(IW'($urandom), len, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), 1'b0, '0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
